wishbone_master_arbiter_n: RTL

Parametrised successor to the 4-master Wishbone bus arbiter: arbitrates N masters onto the shared interconnect. It supports run-time selectable round-robin or fixed-priority ordering, and a hold-cycle limit that preempts a master monopolising the bus unless that master asserts lock. It sits in the WishboneInterconnect ahead of the master-side mux, which consumes `masterSelected`/`grant`.

---
 rtl/wishbone_master_arbiter_n_pkg.sv | 16 +
 rtl/rotating_priority_encoder.sv | 39 +++
 rtl/wishbone_master_arbiter_n.sv | 106 ++++++++++
 3 files changed

// File: rtl/wishbone_master_arbiter_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_master_arbiter_n_pkg
// Description : Shared constants and types for the N-master Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wishbone_master_arbiter_n_pkg;

    localparam logic c_PRIORITY_ROUND_ROBIN = 1'b0;
    localparam logic c_PRIORITY_FIXED       = 1'b1;
    localparam int   c_HOLD_COUNT_WIDTH     = 8;

    typedef logic [c_HOLD_COUNT_WIDTH-1:0] hold_count_t;

endpackage : wishbone_master_arbiter_n_pkg
`default_nettype wire

// File: rtl/rotating_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rotating_priority_encoder
// Description : Finds the first set request at or after a start index
//               (wrapping modulo N), skipping one excluded index.
// Revision    : 1.0 - initial release
// ============================================================================
module rotating_priority_encoder #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [IW-1:0] i_start,
    input  logic [IW-1:0] i_exclude,
    output logic          o_found,
    output logic [IW-1:0] o_index
);

    // One spare bit so start+offset can exceed N before the wrap.
    logic [IW:0] w_pos;

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int off = 0; off < N; off++) begin
            w_pos = {1'b0, i_start} + (IW+1)'(off);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!o_found && i_request[w_pos[IW-1:0]] && (w_pos[IW-1:0] != i_exclude)) begin
                o_found = 1'b1;
                o_index = w_pos[IW-1:0];
            end
        end
    end

endmodule : rotating_priority_encoder
`default_nettype wire

// File: rtl/wishbone_master_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_master_arbiter_n
// Description : N-master Wishbone arbiter, round-robin or fixed priority,
//               with hold-limit preemption suppressed by lock.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_master_arbiter_n
    import wishbone_master_arbiter_n_pkg::*;
#(
    parameter  int MASTER_COUNT    = 4,
    parameter  int MAX_HOLD_CYCLES = 16,
    localparam int INDEX_WIDTH     = $clog2(MASTER_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MASTER_COUNT-1:0] request,
    input  logic [MASTER_COUNT-1:0] lock,
    input  logic                    priorityMode,
    output logic [INDEX_WIDTH-1:0]  masterSelected,
    output logic [MASTER_COUNT-1:0] grant,
    output logic                    grantValid,
    output logic                    preempt
);

    localparam hold_count_t c_HOLD_MAX = hold_count_t'(MAX_HOLD_CYCLES);

    logic [INDEX_WIDTH-1:0] r_current_master_q;
    logic [INDEX_WIDTH-1:0] w_current_master_d;
    hold_count_t            r_hold_count_q;
    hold_count_t            w_hold_count_d;

    logic                   w_cur_request;
    logic                   w_cur_lock;
    logic [INDEX_WIDTH:0]   w_cur_plus_one;
    logic [INDEX_WIDTH-1:0] w_search_start;
    logic                   w_found;
    logic [INDEX_WIDTH-1:0] w_found_index;
    logic                   w_release;
    logic                   w_preempt;
    logic [c_HOLD_COUNT_WIDTH:0] w_hold_inc;

    assign w_cur_request = request[r_current_master_q];
    assign w_cur_lock    = lock[r_current_master_q];

    always_comb begin
        w_cur_plus_one = {1'b0, r_current_master_q} + 1'b1;
        if (w_cur_plus_one == (INDEX_WIDTH+1)'(MASTER_COUNT)) begin
            w_cur_plus_one = '0;
        end
        w_search_start = (priorityMode == c_PRIORITY_FIXED) ? '0
                                                            : w_cur_plus_one[INDEX_WIDTH-1:0];
    end

    rotating_priority_encoder #(
        .N  (MASTER_COUNT),
        .IW (INDEX_WIDTH)
    ) u_search (
        .i_request (request),
        .i_start   (w_search_start),
        .i_exclude (r_current_master_q),
        .o_found   (w_found),
        .o_index   (w_found_index)
    );

    assign w_release = !w_cur_request && w_found;
    assign w_preempt = (MAX_HOLD_CYCLES != 0) && w_cur_request && !w_cur_lock
                       && (r_hold_count_q == c_HOLD_MAX) && w_found;

    always_comb begin
        w_current_master_d = (w_release || w_preempt) ? w_found_index : r_current_master_q;

        w_hold_inc = {1'b0, r_hold_count_q} + 1'b1;
        if (w_current_master_d != r_current_master_q) begin
            w_hold_count_d = hold_count_t'(1);
        end else if (w_cur_request) begin
            w_hold_count_d = (w_hold_inc > {1'b0, c_HOLD_MAX}) ? c_HOLD_MAX
                                                               : w_hold_inc[c_HOLD_COUNT_WIDTH-1:0];
        end else begin
            w_hold_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_current_master_q <= '0;
            r_hold_count_q     <= '0;
        end else begin
            r_current_master_q <= w_current_master_d;
            r_hold_count_q     <= w_hold_count_d;
        end
    end

    // Outputs are forced quiet for the whole reset window, not just after it.
    always_comb begin
        masterSelected = rst ? '0 : w_current_master_d;
        grantValid     = !rst && request[w_current_master_d];
        preempt        = !rst && w_preempt;
        grant          = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            grant[i] = grantValid && (w_current_master_d == INDEX_WIDTH'(i));
        end
    end

endmodule : wishbone_master_arbiter_n
`default_nettype wire
